// File: rtl/msg_schedule_if.sv
// msg_schedule_if: block-in / schedule-word-out signals of the SHA-256 message schedule stage
interface msg_schedule_if;
  logic         message_vector_complete;
  logic [511:0] message_vector;
  logic         w_ready;
  logic         w_valid;
  logic [31:0]  w_word;
  logic [5:0]   w_index;
  logic         busy;
  logic         schedule_complete;
  modport master (
    input  message_vector_complete, message_vector, w_ready,
    output w_valid, w_word, w_index, busy, schedule_complete
  );
  modport slave (
    output message_vector_complete, message_vector, w_ready,
    input  w_valid, w_word, w_index, busy, schedule_complete
  );
endinterface

// File: rtl/msg_schedule.sv
// msg_schedule: streams SHA-256 schedule words W0..W63 from a 16-word sliding window
module msg_schedule #(
  parameter int WORD_W     = 32,
  parameter int NUM_ROUNDS = 64
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           enable,
  msg_schedule_if.master bus
);
  typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;
  state_t            state, state_nx;
  logic [WORD_W-1:0] win [16];
  logic [5:0]        idx;
  logic [WORD_W-1:0] w_new;
  logic              accept, last;
  function automatic logic [31:0] s0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction
  function automatic logic [31:0] s1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction
  assign accept = state == EMIT && bus.w_ready;
  assign last   = idx == 6'(NUM_ROUNDS - 1);
  assign w_new  = s1(win[14]) + win[9] + s0(win[1]) + win[0];
  always_comb begin
    state_nx = state;
    if (!enable) state_nx = IDLE;
    else if (state == IDLE && bus.message_vector_complete) state_nx = EMIT;
    else if (accept && last) state_nx = DONE;
    else if (state == DONE) state_nx = IDLE;
  end
  always_ff @(posedge clock or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  // Window only moves on an accept, so a stall holds w_word/w_index for free.
  always_ff @(posedge clock or negedge reset)
    if (!reset) begin
      for (int i = 0; i < 16; i++) win[i] <= '0;
      idx <= '0;
    end else if (!enable) begin
      idx <= '0;
    end else if (state == IDLE && bus.message_vector_complete) begin
      for (int i = 0; i < 16; i++) win[i] <= bus.message_vector[511-32*i -: 32];
      idx <= '0;
    end else if (accept) begin
      for (int i = 0; i < 15; i++) win[i] <= win[i+1];
      win[15] <= w_new;
      idx     <= idx + 6'd1;
    end
  assign bus.w_valid           = state == EMIT;
  assign bus.w_word            = win[0];
  assign bus.w_index           = idx;
  assign bus.busy              = state != IDLE;
  assign bus.schedule_complete = state == DONE;
endmodule

// File: tb/tb_msg_schedule.sv
// tb_msg_schedule: randomized self-checking bench against a plain-array SHA-256 schedule model
module tb_msg_schedule;
  logic clock = 0, reset = 0, enable = 0;
  int errors = 0, checks = 0;
  typedef logic [31:0] wv_t [64];
  logic [511:0] abc_blk;
  msg_schedule_if bus();
  msg_schedule dut (.clock(clock), .reset(reset), .enable(enable), .bus(bus));
  always #5 clock = ~clock;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic void expand(input logic [511:0] b, output wv_t w);
    for (int t = 0; t < 16; t++) w[t] = b[511-32*t -: 32];
    for (int t = 16; t < 64; t++)
      w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
           + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
  endfunction

  function automatic logic [511:0] rnd_blk();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[511-32*i -: 32] = $urandom;
    return b;
  endfunction

  task automatic start(input logic [511:0] b, input bit hold);
    bus.message_vector = b;
    bus.message_vector_complete = 1;
    enable = 1;
    @(negedge clock);
    if (!hold) bus.message_vector_complete = 0;
  endtask

  // Consumer: mode 0 always ready, mode 1 random ready with 5-cycle stalls at 15/16/63.
  // Returns at the schedule_complete negedge, at stop_idx (unaccepted), or on budget expiry.
  task automatic collect(input int mode, input int stop_idx, input int alt_idx, input logic [511:0] alt_blk,
                         output wv_t words, output int nacc, output int stall_viol, output int idx_viol,
                         output int gap, output int pulses, output bit timeout);
    logic [31:0] hold_w = 0;
    logic [5:0]  hold_i = 0;
    bit stalled = 0, alt_done = 0, alt_clr = 0, rdy, hot;
    int cnt = 0, since = 0;
    nacc = 0; stall_viol = 0; idx_viol = 0; gap = -1; pulses = 0; timeout = 1;
    for (int t = 0; t < 64; t++) words[t] = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (nacc >= 64) since++;
      if (bus.schedule_complete) begin pulses++; if (gap < 0) gap = since; end
      if (stalled && (bus.w_valid !== 1'b1 || bus.w_word !== hold_w || bus.w_index !== hold_i)) stall_viol++;
      if (nacc >= 64 && (bus.schedule_complete || since > 3)) begin timeout = 0; return; end
      if (stop_idx >= 0 && bus.w_valid && bus.w_index == 6'(stop_idx)) begin
        bus.w_ready = 0; timeout = 0; return;
      end
      if (alt_clr) begin bus.message_vector_complete = 0; alt_clr = 0; end
      if (alt_idx >= 0 && !alt_done && bus.w_valid && bus.w_index == 6'(alt_idx)) begin
        bus.message_vector = alt_blk; bus.message_vector_complete = 1; alt_done = 1; alt_clr = 1;
      end
      hot = mode == 1 && (bus.w_index == 15 || bus.w_index == 16 || bus.w_index == 63);
      rdy = mode == 0 ? 1'b1 : hot ? (cnt >= 5) : 1'($urandom_range(0, 1));
      bus.w_ready = rdy;
      stalled = bus.w_valid && !rdy;
      if (stalled) begin hold_w = bus.w_word; hold_i = bus.w_index; if (hot) cnt++; end
      if (bus.w_valid && rdy) begin
        if (nacc < 64) words[nacc] = bus.w_word;
        if (bus.w_index !== 6'(nacc)) idx_viol++;
        nacc++; cnt = 0;
      end
      @(negedge clock);
    end
  endtask

  task automatic test_reset();
    bus.message_vector = abc_blk; bus.message_vector_complete = 1; bus.w_ready = 1; enable = 1;
    repeat (2) @(negedge clock);
    checks++; if (bus.w_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.w_valid); end
    checks++; if (bus.w_word !== 32'h0) begin errors++; $display("FAIL reset_word: got %h want 0", bus.w_word); end
    checks++; if (bus.w_index !== 6'd0) begin errors++; $display("FAIL reset_index: got %0d want 0", bus.w_index); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    checks++; if (bus.schedule_complete !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", bus.schedule_complete); end
    bus.message_vector_complete = 0;
    reset = 1;
    @(negedge clock);
  endtask

  task automatic test_abc();
    wv_t m, got; int nacc, sv, iv, gap, pulses; bit to;
    expand(abc_blk, m);
    start(abc_blk, 0);
    checks++; if (bus.w_valid !== 1'b1 || bus.busy !== 1'b1) begin errors++; $display("FAIL abc_latency: valid=%b busy=%b want 1 1", bus.w_valid, bus.busy); end
    collect(0, -1, -1, '0, got, nacc, sv, iv, gap, pulses, to);
    checks++; if (to) begin errors++; $display("FAIL abc_timeout: stream did not finish, accepts=%0d want 64", nacc); end
    for (int t = 0; t < 64; t++) begin
      checks++; if (got[t] !== m[t]) begin errors++; $display("FAIL abc_W%0d: got %h want %h", t, got[t], m[t]); end
    end
    checks++; if (got[15] !== 32'h18 || got[16] !== 32'h61626380) begin errors++; $display("FAIL abc_W15_16: got %h %h want 00000018 61626380", got[15], got[16]); end
    checks++; if (got[17] !== 32'h000F0000 || got[18] !== 32'h7DA86405) begin errors++; $display("FAIL abc_W17_18: got %h %h want 000f0000 7da86405", got[17], got[18]); end
    checks++; if (nacc !== 64 || iv !== 0) begin errors++; $display("FAIL abc_count: accepts=%0d index_errs=%0d want 64 0", nacc, iv); end
    checks++; if (gap !== 1 || pulses !== 1) begin errors++; $display("FAIL abc_done_pulse: gap=%0d pulses=%0d want 1 1", gap, pulses); end
    checks++; if (bus.w_valid !== 1'b0) begin errors++; $display("FAIL abc_valid_drop: got %b want 0", bus.w_valid); end
    @(negedge clock);
    checks++; if (bus.schedule_complete !== 1'b0 || bus.busy !== 1'b0) begin errors++; $display("FAIL abc_idle: done=%b busy=%b want 0 0", bus.schedule_complete, bus.busy); end
  endtask

  task automatic test_zero();
    wv_t got; int nacc, sv, iv, gap, pulses, nz; bit to;
    start('0, 0);
    collect(0, -1, -1, '0, got, nacc, sv, iv, gap, pulses, to);
    nz = 0;
    for (int t = 0; t < 64; t++) if (got[t] !== 32'h0) nz++;
    checks++; if (nz !== 0) begin errors++; $display("FAIL zero_words: nonzero=%0d want 0", nz); end
    checks++; if (to || nacc !== 64 || iv !== 0) begin errors++; $display("FAIL zero_count: accepts=%0d index_errs=%0d timeout=%b want 64 0 0", nacc, iv, to); end
    checks++; if (pulses !== 1) begin errors++; $display("FAIL zero_pulses: got %0d want 1", pulses); end
    @(negedge clock);
  endtask

  task automatic test_stall();
    wv_t m, got; int nacc, sv, iv, gap, pulses; bit to;
    expand(abc_blk, m);
    start(abc_blk, 0);
    collect(1, -1, -1, '0, got, nacc, sv, iv, gap, pulses, to);
    for (int t = 0; t < 64; t++) begin
      checks++; if (got[t] !== m[t]) begin errors++; $display("FAIL stall_W%0d: got %h want %h", t, got[t], m[t]); end
    end
    checks++; if (sv !== 0) begin errors++; $display("FAIL stall_hold: violations=%0d want 0", sv); end
    checks++; if (to || nacc !== 64 || iv !== 0 || pulses !== 1) begin errors++; $display("FAIL stall_count: accepts=%0d index_errs=%0d pulses=%0d want 64 0 1", nacc, iv, pulses); end
    @(negedge clock);
  endtask

  task automatic test_ignore_start();
    wv_t m, mb, got; int nacc, sv, iv, gap, pulses; bit to;
    logic [511:0] b = rnd_blk();
    expand(abc_blk, m); expand(b, mb);
    start(abc_blk, 0);
    collect(0, -1, 30, b, got, nacc, sv, iv, gap, pulses, to);
    for (int t = 0; t < 64; t++) begin
      checks++; if (got[t] !== m[t]) begin errors++; $display("FAIL ignore_W%0d: got %h want %h", t, got[t], m[t]); end
    end
    checks++; if (to || nacc !== 64 || pulses !== 1) begin errors++; $display("FAIL ignore_count: accepts=%0d pulses=%0d want 64 1", nacc, pulses); end
    @(negedge clock);
    start(b, 0);
    checks++; if (bus.w_valid !== 1'b1 || bus.w_word !== mb[0] || bus.w_index !== 6'd0) begin errors++; $display("FAIL ignore_restart: valid=%b word=%h idx=%0d want 1 %h 0", bus.w_valid, bus.w_word, bus.w_index, mb[0]); end
    collect(0, -1, -1, '0, got, nacc, sv, iv, gap, pulses, to);
    for (int t = 0; t < 64; t++) begin
      checks++; if (got[t] !== mb[t]) begin errors++; $display("FAIL ignore_new_W%0d: got %h want %h", t, got[t], mb[t]); end
    end
    @(negedge clock);
  endtask

  task automatic test_async_reset();
    wv_t mb, got; int nacc, sv, iv, gap, pulses, sc = 0; bit to;
    logic [511:0] b = rnd_blk();
    expand(b, mb);
    start(rnd_blk(), 0);
    collect(0, 40, -1, '0, got, nacc, sv, iv, gap, pulses, to);
    checks++; if (to || nacc !== 40) begin errors++; $display("FAIL areset_reach: accepts=%0d want 40", nacc); end
    reset = 0;
    #1;
    checks++; if (bus.w_valid !== 1'b0 || bus.w_word !== 32'h0 || bus.w_index !== 6'd0 || bus.busy !== 1'b0)
      begin errors++; $display("FAIL areset_outputs: valid=%b word=%h idx=%0d busy=%b want 0 0 0 0", bus.w_valid, bus.w_word, bus.w_index, bus.busy); end
    repeat (3) begin @(negedge clock); if (bus.schedule_complete) sc++; end
    checks++; if (sc !== 0) begin errors++; $display("FAIL areset_no_done: pulses=%0d want 0", sc); end
    reset = 1;
    start(b, 0);
    checks++; if (bus.w_valid !== 1'b1 || bus.w_word !== mb[0] || bus.w_index !== 6'd0) begin errors++; $display("FAIL areset_restart: valid=%b word=%h idx=%0d want 1 %h 0", bus.w_valid, bus.w_word, bus.w_index, mb[0]); end
    collect(0, -1, -1, '0, got, nacc, sv, iv, gap, pulses, to);
    for (int t = 0; t < 64; t++) begin
      checks++; if (got[t] !== mb[t]) begin errors++; $display("FAIL areset_W%0d: got %h want %h", t, got[t], mb[t]); end
    end
    @(negedge clock);
  endtask

  task automatic test_enable();
    wv_t mb, got; int nacc, sv, iv, gap, pulses; bit to;
    logic [511:0] b = rnd_blk();
    expand(b, mb);
    start(rnd_blk(), 0);
    collect(0, 20, -1, '0, got, nacc, sv, iv, gap, pulses, to);
    enable = 0;
    @(negedge clock);
    checks++; if (bus.w_valid !== 1'b0 || bus.w_index !== 6'd0 || bus.busy !== 1'b0 || bus.schedule_complete !== 1'b0)
      begin errors++; $display("FAIL enable_abort: valid=%b idx=%0d busy=%b done=%b want 0 0 0 0", bus.w_valid, bus.w_index, bus.busy, bus.schedule_complete); end
    start(b, 0);
    checks++; if (bus.w_valid !== 1'b1 || bus.w_word !== mb[0] || bus.w_index !== 6'd0) begin errors++; $display("FAIL enable_restart: valid=%b word=%h idx=%0d want 1 %h 0", bus.w_valid, bus.w_word, bus.w_index, mb[0]); end
    collect(1, -1, -1, '0, got, nacc, sv, iv, gap, pulses, to);
    for (int t = 0; t < 64; t++) begin
      checks++; if (got[t] !== mb[t]) begin errors++; $display("FAIL enable_W%0d: got %h want %h", t, got[t], mb[t]); end
    end
    checks++; if (to || nacc !== 64 || pulses !== 1) begin errors++; $display("FAIL enable_count: accepts=%0d pulses=%0d want 64 1", nacc, pulses); end
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    wv_t ma, mb, got; int nacc, sv, iv, gap, pulses; bit to;
    logic [511:0] a = rnd_blk(), b = rnd_blk();
    expand(a, ma); expand(b, mb);
    start(a, 1);
    collect(0, -1, -1, '0, got, nacc, sv, iv, gap, pulses, to);
    for (int t = 0; t < 64; t++) begin
      checks++; if (got[t] !== ma[t]) begin errors++; $display("FAIL b2b_a_W%0d: got %h want %h", t, got[t], ma[t]); end
    end
    bus.message_vector = b;
    @(negedge clock);
    checks++; if (bus.busy !== 1'b0 || bus.w_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle_gap: busy=%b valid=%b want 0 0", bus.busy, bus.w_valid); end
    @(negedge clock);
    checks++; if (bus.w_valid !== 1'b1 || bus.w_word !== mb[0] || bus.w_index !== 6'd0) begin errors++; $display("FAIL b2b_second_start: valid=%b word=%h idx=%0d want 1 %h 0", bus.w_valid, bus.w_word, bus.w_index, mb[0]); end
    bus.message_vector_complete = 0;
    collect(0, -1, -1, '0, got, nacc, sv, iv, gap, pulses, to);
    for (int t = 0; t < 64; t++) begin
      checks++; if (got[t] !== mb[t]) begin errors++; $display("FAIL b2b_b_W%0d: got %h want %h", t, got[t], mb[t]); end
    end
    checks++; if (to || nacc !== 64 || pulses !== 1) begin errors++; $display("FAIL b2b_count: accepts=%0d pulses=%0d want 64 1", nacc, pulses); end
    @(negedge clock);
  endtask

  initial begin
    abc_blk = '0;
    abc_blk[511:480] = 32'h61626380;
    abc_blk[31:0] = 32'h00000018;
    bus.message_vector = '0;
    bus.message_vector_complete = 0;
    bus.w_ready = 0;
    test_reset();
    test_abc();
    test_zero();
    test_stall();
    test_ignore_start();
    test_async_reset();
    test_enable();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
